// File: rtl/spi_responder_pkg.sv
// Shared definitions for the SPI responder: CSR map, CSR bit positions and the FILL reset default.
package spi_responder_pkg;

    typedef enum logic [1:0] {
        AddrCsr  = 2'd0,
        AddrData = 2'd1,
        AddrFill = 2'd2,
        AddrRsvd = 2'd3
    } reg_addr_e;

    localparam int unsigned CsrRxValid  = 0;
    localparam int unsigned CsrTxEmpty  = 1;
    localparam int unsigned CsrRxOvr    = 2;
    localparam int unsigned CsrTxUdr    = 3;
    localparam int unsigned CsrCsActive = 4;
    localparam int unsigned CsrIrqEna   = 7;
    localparam int unsigned DataRxValid = 31;

    localparam logic [7:0] FillRstDefault = 8'hFF;

endpackage

// File: rtl/spi_responder_if.sv
// Wishbone-style CSR window of the SPI responder.
interface spi_responder_if;
    logic [1:0]  wb_addr;
    logic [31:0] wb_rdata;
    logic [31:0] wb_wdata;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_ack;

    modport master (output wb_addr, wb_wdata, wb_we, wb_cyc, input wb_rdata, wb_ack);
    modport slave  (input wb_addr, wb_wdata, wb_we, wb_cyc, output wb_rdata, wb_ack);
endinterface

// File: rtl/spi_responder_sync.sv
// Pad synchronizers for MOSI/SCLK/CS_N with single-clk edge pulses for SCLK and CS_N.
module spi_responder_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic mosi_pad,
    input  logic sclk_pad,
    input  logic cs_n_pad,
    output logic mosi,
    output logic cs_n,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_fall,
    output logic cs_rise
);
    // Stage [0] is the input-register stage at the pad.
    logic [2:0] sclk_q;
    logic [2:0] cs_n_q;
    logic [1:0] mosi_q;

    // CS_N resets to "selected" so a frame already running at reset can never arm the responder.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_q <= 3'b000;
            cs_n_q <= 3'b000;
            mosi_q <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk_pad};
            cs_n_q <= {cs_n_q[1:0], cs_n_pad};
            mosi_q <= {mosi_q[0], mosi_pad};
        end
    end

    assign mosi      = mosi_q[1];
    assign cs_n      = cs_n_q[2];
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_fall   = ~cs_n_q[1] & cs_n_q[2];
    assign cs_rise   = cs_n_q[1] & ~cs_n_q[2];
endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 8-bit target with single-byte RX/TX holding registers and a 4-word CSR window.
module spi_responder
    import spi_responder_pkg::*;
#(
    parameter logic [7:0] FillRst = FillRstDefault
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           spi_pad_mosi,
    inout  wire            spi_pad_miso,
    input  logic           spi_pad_clk,
    input  logic           spi_pad_cs_n,
    output logic           irqo_spi,
    spi_responder_if.slave wb
);
    logic mosi_s, cs_n_s, sclk_rise, sclk_fall, cs_fall, cs_rise;

    spi_responder_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .mosi_pad  (spi_pad_mosi),
        .sclk_pad  (spi_pad_clk),
        .cs_n_pad  (spi_pad_cs_n),
        .mosi      (mosi_s),
        .cs_n      (cs_n_s),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise)
    );

    logic        ack_q, wr_stb_q, irq_q, miso_q;
    logic [31:0] rdata_q, rdata_d;
    reg_addr_e   wr_addr_q;
    logic [7:0]  wr_data_q;
    logic        armed_q, armed_d, oe_q, oe_d;
    logic        rx_valid_q, rx_valid_d, tx_valid_q, tx_valid_d;
    logic        rx_ovr_q, rx_ovr_d, tx_udr_q, tx_udr_d, udr_pend_q, udr_pend_d;
    logic        irq_ena_q, irq_ena_d, reload_pend_q, reload_pend_d;
    logic [7:0]  tx_hold_q, tx_hold_d, fill_q, fill_d, rx_data_q, rx_data_d;
    logic [7:0]  shift_rx_q, shift_rx_d, shift_tx_q, shift_tx_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        load, from_reload, rd_clr;
    logic        unused_wdata;

    assign unused_wdata = ^wb.wb_wdata[31:8];
    assign rd_clr = ack_q & wb.wb_cyc & ~wb.wb_we & (reg_addr_e'(wb.wb_addr) == AddrData);

    always_comb begin
        rdata_d = '0;
        if (wb.wb_cyc && !ack_q) begin
            unique case (reg_addr_e'(wb.wb_addr))
                AddrCsr: begin
                    rdata_d[CsrRxValid]  = rx_valid_q;
                    rdata_d[CsrTxEmpty]  = ~tx_valid_q;
                    rdata_d[CsrRxOvr]    = rx_ovr_q;
                    rdata_d[CsrTxUdr]    = tx_udr_q;
                    rdata_d[CsrCsActive] = oe_q;
                    rdata_d[CsrIrqEna]   = irq_ena_q;
                end
                AddrData: rdata_d = {rx_valid_q, 23'd0, rx_data_q};
                AddrFill: rdata_d = {24'd0, fill_q};
                default:  rdata_d = '0;
            endcase
        end
    end

    // Bus writes and clears come first so same-clk hardware sets override them.
    always_comb begin
        armed_d       = armed_q | cs_n_s;
        oe_d          = oe_q;
        rx_valid_d    = rx_valid_q;
        tx_valid_d    = tx_valid_q;
        rx_ovr_d      = rx_ovr_q;
        tx_udr_d      = tx_udr_q;
        udr_pend_d    = udr_pend_q;
        irq_ena_d     = irq_ena_q;
        reload_pend_d = reload_pend_q;
        tx_hold_d     = tx_hold_q;
        fill_d        = fill_q;
        rx_data_d     = rx_data_q;
        shift_rx_d    = shift_rx_q;
        shift_tx_d    = shift_tx_q;
        bit_cnt_d     = bit_cnt_q;
        load          = 1'b0;
        from_reload   = 1'b0;

        if (wr_stb_q && wr_addr_q == AddrCsr) begin
            irq_ena_d = wr_data_q[CsrIrqEna];
            if (wr_data_q[CsrRxOvr]) rx_ovr_d = 1'b0;
            if (wr_data_q[CsrTxUdr]) tx_udr_d = 1'b0;
        end
        if (wr_stb_q && wr_addr_q == AddrFill) fill_d = wr_data_q;
        if (rd_clr) rx_valid_d = 1'b0;

        if (cs_fall && armed_q) begin
            oe_d          = 1'b1;
            bit_cnt_d     = '0;
            reload_pend_d = 1'b0;
            load          = 1'b1;
        end else if (cs_rise) begin
            oe_d          = 1'b0;
            bit_cnt_d     = '0;
            reload_pend_d = 1'b0;
            udr_pend_d    = 1'b0;
        end else if (oe_q && sclk_rise) begin
            shift_rx_d = {shift_rx_q[6:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            // Underrun after a byte boundary counts only once the fill byte starts shifting.
            if (udr_pend_q) begin
                tx_udr_d   = 1'b1;
                udr_pend_d = 1'b0;
            end
            if (bit_cnt_q == 3'd7) begin
                rx_data_d     = shift_rx_d;
                rx_valid_d    = 1'b1;
                reload_pend_d = 1'b1;
                if (rx_valid_q && !rd_clr) rx_ovr_d = 1'b1;
            end
        end else if (oe_q && sclk_fall) begin
            if (reload_pend_q) begin
                load          = 1'b1;
                from_reload   = 1'b1;
                reload_pend_d = 1'b0;
            end else begin
                shift_tx_d = {shift_tx_q[6:0], 1'b0};
            end
        end

        if (load) begin
            if (tx_valid_q) begin
                shift_tx_d = tx_hold_q;
                tx_valid_d = 1'b0;
            end else begin
                shift_tx_d = fill_q;
                if (from_reload) udr_pend_d = 1'b1;
                else             tx_udr_d   = 1'b1;
            end
        end
        if (wr_stb_q && wr_addr_q == AddrData) begin
            tx_hold_d  = wr_data_q;
            tx_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_q <= 1'b0;          wr_stb_q <= 1'b0;       wr_addr_q <= AddrCsr;
            wr_data_q <= '0;        rdata_q <= '0;          irq_q <= 1'b0;
            miso_q <= 1'b0;         armed_q <= 1'b0;        oe_q <= 1'b0;
            rx_valid_q <= 1'b0;     tx_valid_q <= 1'b0;     rx_ovr_q <= 1'b0;
            tx_udr_q <= 1'b0;       udr_pend_q <= 1'b0;     irq_ena_q <= 1'b0;
            reload_pend_q <= 1'b0;  tx_hold_q <= '0;        fill_q <= FillRst;
            rx_data_q <= '0;        shift_rx_q <= '0;       shift_tx_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            ack_q <= wb.wb_cyc & ~ack_q;
            wr_stb_q <= wb.wb_cyc & wb.wb_we & ~ack_q;
            wr_addr_q <= reg_addr_e'(wb.wb_addr);
            wr_data_q <= wb.wb_wdata[7:0];
            rdata_q <= rdata_d;
            irq_q <= irq_ena_q & (rx_valid_q | rx_ovr_q | tx_udr_q);
            miso_q <= shift_tx_q[7];
            armed_q <= armed_d;     oe_q <= oe_d;
            rx_valid_q <= rx_valid_d;  tx_valid_q <= tx_valid_d;
            rx_ovr_q <= rx_ovr_d;   tx_udr_q <= tx_udr_d;   udr_pend_q <= udr_pend_d;
            irq_ena_q <= irq_ena_d; reload_pend_q <= reload_pend_d;
            tx_hold_q <= tx_hold_d; fill_q <= fill_d;       rx_data_q <= rx_data_d;
            shift_rx_q <= shift_rx_d;  shift_tx_q <= shift_tx_d;  bit_cnt_q <= bit_cnt_d;
        end
    end

    assign wb.wb_ack   = ack_q;
    assign wb.wb_rdata = rdata_q;
    assign irqo_spi    = irq_q;
    assign spi_pad_miso = oe_q ? miso_q : 1'bz;
endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: register table, SPI master model, and queue-based MISO/RX scoreboards.
module tb_spi_responder;
    import spi_responder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, mosi, sclk, cs_n, irq;
    wire  miso;

    spi_responder_if wb_bus ();

    spi_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_pad_mosi (mosi),
        .spi_pad_miso (miso),
        .spi_pad_clk  (sclk),
        .spi_pad_cs_n (cs_n),
        .irqo_spi     (irq),
        .wb           (wb_bus)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_miso[$];
    logic [7:0] exp_rx[$];

    typedef struct packed {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } reg_vec_t;
    reg_vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    // Called at a negedge; holds cyc through the ack cycle.
    task automatic wb_xfer(input logic we, input logic [1:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata);
        int n = 0;
        wb_bus.wb_cyc = 1'b1;
        wb_bus.wb_we = we;
        wb_bus.wb_addr = addr;
        wb_bus.wb_wdata = wdata;
        do begin
            @(negedge clk);
            n++;
        end while (!wb_bus.wb_ack && n < 10);
        check("wb_ack", {31'd0, wb_bus.wb_ack}, 32'd1);
        rdata = wb_bus.wb_rdata;
        @(negedge clk);
        wb_bus.wb_cyc = 1'b0;
        wb_bus.wb_we = 1'b0;
    endtask

    task automatic wb_write(input logic [1:0] addr, input logic [31:0] wdata);
        logic [31:0] d;
        wb_xfer(1'b1, addr, wdata, d);
    endtask

    task automatic wb_check(input string name, input logic [1:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        wb_xfer(1'b0, addr, 32'h0, d);
        check(name, d, exp);
    endtask

    // Overwrite model: only the most recently received byte survives until DATA is read.
    task automatic data_check(input string name);
        logic [31:0] e;
        e = (exp_rx.size() != 0) ? {1'b1, 23'd0, exp_rx[$]} : 32'h0;
        exp_rx.delete();
        wb_check(name, 2'(AddrData), e);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i > 7 - n; i--) begin
            mosi = tx[i];
            repeat (8) @(negedge clk);
            rx[i] = miso;
            sclk = 1'b1;
            repeat (8) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_byte(input string name, input logic [7:0] tx);
        logic [7:0] rx;
        spi_bits(tx, 8, rx);
        exp_rx.push_back(tx);
        if (exp_miso.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got %02h want <none queued>", name, rx);
        end else begin
            check(name, {24'd0, rx}, {24'd0, exp_miso.pop_front()});
        end
    endtask

    task automatic cs_high();
        repeat (8) @(negedge clk);
        cs_n = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    initial begin
        logic [7:0] junk;
        rst_n = 1'b0; mosi = 1'b0; sclk = 1'b0; cs_n = 1'b1;
        wb_bus.wb_cyc = 1'b0; wb_bus.wb_we = 1'b0; wb_bus.wb_addr = '0; wb_bus.wb_wdata = '0;
        repeat (4) @(negedge clk);
        check("rst_ack", {31'd0, wb_bus.wb_ack}, 32'd0);
        check("rst_rdata", wb_bus.wb_rdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        tbl[0]  = '{1'b0, 2'd0, 32'h0,        32'h0000_0002};
        tbl[1]  = '{1'b0, 2'd1, 32'h0,        32'h0000_0000};
        tbl[2]  = '{1'b0, 2'd2, 32'h0,        32'h0000_00FF};
        tbl[3]  = '{1'b0, 2'd3, 32'h0,        32'h0000_0000};
        tbl[4]  = '{1'b1, 2'd2, 32'hFFFF_FF5A, 32'h0};
        tbl[5]  = '{1'b0, 2'd2, 32'h0,        32'h0000_005A};
        tbl[6]  = '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0};
        tbl[7]  = '{1'b0, 2'd3, 32'h0,        32'h0000_0000};
        tbl[8]  = '{1'b1, 2'd0, 32'h0000_0080, 32'h0};
        tbl[9]  = '{1'b0, 2'd0, 32'h0,        32'h0000_0082};
        tbl[10] = '{1'b1, 2'd0, 32'h0000_0000, 32'h0};
        tbl[11] = '{1'b0, 2'd0, 32'h0,        32'h0000_0002};
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].we) wb_write(tbl[i].addr, tbl[i].wdata);
            else wb_check($sformatf("tbl[%0d]", i), tbl[i].addr, tbl[i].exp);
        end

        // T1: pending TX byte goes out while a byte comes in.
        wb_write(2'(AddrData), 32'hA5);
        exp_miso.push_back(8'hA5);
        wb_check("t1_csr_pre", 2'(AddrCsr), 32'h00);
        cs_n = 1'b0;
        spi_byte("t1_miso", 8'h3C);
        cs_high();
        wb_check("t1_csr", 2'(AddrCsr), 32'h03);
        data_check("t1_data");
        wb_check("t1_csr_post", 2'(AddrCsr), 32'h02);

        // T2: underrun sends FILL twice; W1C on tx_udr.
        wb_write(2'(AddrFill), 32'h5A);
        exp_miso.push_back(8'h5A);
        exp_miso.push_back(8'h5A);
        cs_n = 1'b0;
        spi_byte("t2_miso0", 8'h01);
        spi_byte("t2_miso1", 8'h02);
        cs_high();
        wb_check("t2_csr", 2'(AddrCsr), 32'h0F);
        check("t2_irq_off", {31'd0, irq}, 32'd0);
        wb_write(2'(AddrCsr), 32'h08);
        wb_check("t2_csr_w1c", 2'(AddrCsr), 32'h07);
        wb_write(2'(AddrCsr), 32'h04);
        data_check("t2_data");

        // T3: overrun with interrupt enabled.
        wb_write(2'(AddrCsr), 32'h8C);
        exp_miso.push_back(8'h5A);
        exp_miso.push_back(8'h5A);
        cs_n = 1'b0;
        spi_byte("t3_miso0", 8'h11);
        spi_byte("t3_miso1", 8'h22);
        cs_high();
        wb_check("t3_csr", 2'(AddrCsr), 32'h8F);
        check("t3_irq_on", {31'd0, irq}, 32'd1);
        data_check("t3_data");
        wb_write(2'(AddrCsr), 32'h8C);
        repeat (2) @(negedge clk);
        check("t3_irq_clr", {31'd0, irq}, 32'd0);
        wb_write(2'(AddrCsr), 32'h00);

        // T4: partial frame is discarded, next frame is clean.
        cs_n = 1'b0;
        spi_bits(8'hF0, 5, junk);
        cs_high();
        wb_check("t4_csr_partial", 2'(AddrCsr), 32'h0A);
        wb_write(2'(AddrCsr), 32'h08);
        wb_write(2'(AddrData), 32'h96);
        exp_miso.push_back(8'h96);
        cs_n = 1'b0;
        spi_byte("t4_miso", 8'h6B);
        cs_high();
        wb_check("t4_csr", 2'(AddrCsr), 32'h03);
        data_check("t4_data");

        // T6: DATA write lands on the same clk as the CS-fall load.
        wb_write(2'(AddrData), 32'h77);
        exp_miso.push_back(8'h77);
        exp_miso.push_back(8'hC3);
        cs_n = 1'b0;
        @(negedge clk);
        wb_write(2'(AddrData), 32'hC3);
        wb_check("t6_csr_mid", 2'(AddrCsr), 32'h10);
        spi_byte("t6_miso0", 8'h5C);
        spi_byte("t6_miso1", 8'hA3);
        cs_high();
        wb_check("t6_csr", 2'(AddrCsr), 32'h07);
        data_check("t6_data");
        wb_write(2'(AddrCsr), 32'h04);

        // T5: reset in mid-frame; the rest of that frame must be ignored.
        cs_n = 1'b0;
        spi_bits(8'hE1, 3, junk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        spi_bits(8'hE1, 5, junk);
        wb_check("t5_csr_ignored", 2'(AddrCsr), 32'h02);
        cs_high();
        wb_check("t5_csr_idle", 2'(AddrCsr), 32'h02);
        wb_check("t5_fill_rst", 2'(AddrFill), 32'hFF);
        wb_write(2'(AddrData), 32'hE7);
        exp_miso.push_back(8'hE7);
        cs_n = 1'b0;
        spi_byte("t5_miso", 8'h42);
        cs_high();
        data_check("t5_data");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
